pcm_lag_frontend: RTL and testbench

//  Upstream feeder of para_approx. Accepts signed PCM mic/reference sample pairs and converts each to IEEE-754 double.

---
 rtl/pcm_lag_pkg.sv | 14 +
 rtl/int_to_double.sv | 35 +++
 rtl/pcm_lag_frontend.sv | 172 +++++++++++++++++
 tb/tb_pcm_lag_frontend.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_lag_pkg.sv
// Shared constants and FSM encoding for the PCM lag front end.
package pcm_lag_pkg;
  localparam int          DOUBLE_W = 64;
  localparam logic [10:0] EXP_BIAS = 11'd1023;
  localparam int          MANT_W   = 52;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONV_MIC = 3'd1,
    CONV_REF = 3'd2,
    COMMIT   = 3'd3,
    STROBE   = 3'd4
  } state_e;
endpackage

// File: rtl/int_to_double.sv
// Exact signed-integer to IEEE-754 double conversion.
// Purely combinational: leading-one detect plus a left shift.
module int_to_double
  import pcm_lag_pkg::*;
#(
  parameter int PCM_W = 16
) (
  input  logic [PCM_W-1:0]    pcm_in,
  output logic [DOUBLE_W-1:0] dbl_out
);
  localparam int POS_W = $clog2(PCM_W);

  logic [PCM_W-1:0]  mag_s;
  logic [POS_W-1:0]  lead_s;
  logic [MANT_W-1:0] mant_s;
  logic [10:0]       exp_s;

  // Magnitude, leading-one position and field assembly
  always_comb begin
    // Unsigned magnitude: the most negative input maps to 2**(PCM_W-1) without overflow.
    mag_s  = pcm_in[PCM_W-1] ? (~pcm_in + PCM_W'(1)) : pcm_in;
    lead_s = '0;
    for (int i = 0; i < PCM_W; i++) begin
      lead_s = mag_s[i] ? POS_W'(i) : lead_s;
    end
    // Shifting the leading one out of the field leaves the bits below it left-aligned.
    mant_s = MANT_W'(mag_s) << (MANT_W - int'(lead_s));
    exp_s  = EXP_BIAS + 11'(lead_s);
    if (mag_s == '0) begin
      dbl_out = '0;
    end else begin
      dbl_out = {pcm_in[PCM_W-1], exp_s, mant_s};
    end
  end
endmodule

// File: rtl/pcm_lag_frontend.sv
// PCM mic/reference front end: holding register, sample-period counter, time-shared
// int->double conversion and a circular history of converted reference samples.
module pcm_lag_frontend
  import pcm_lag_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 620,
  parameter int PCM_W         = 16,
  parameter int LAG_W         = 3
) (
  input  logic             clk_operation,
  input  logic             rst,
  input  logic             enable_sampling,
  input  logic [PCM_W-1:0] pcm_mic,
  input  logic [PCM_W-1:0] pcm_ref,
  input  logic             pcm_valid,
  output logic             pcm_ready,
  input  logic [LAG_W-1:0] lag_sel,
  output logic [63:0]      signal,
  output logic [63:0]      signal_lag,
  output logic             sampling_cycle_counter,
  output logic             underrun
);
  localparam int               CNT_W    = $clog2(SAMPLE_PERIOD);
  localparam int               DEPTH    = 2 ** LAG_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tc_s, accept_s;
  logic               full_q, full_d, ready_q, ready_d;
  logic [PCM_W-1:0]   hold_mic_q, hold_mic_d, hold_ref_q, hold_ref_d;
  logic [PCM_W-1:0]   mic_lat_q, mic_lat_d, ref_lat_q, ref_lat_d;
  logic [63:0]        mic_dbl_q, mic_dbl_d, ref_dbl_q, ref_dbl_d;
  logic [63:0]        hist_q [DEPTH];
  logic [63:0]        hist_d [DEPTH];
  logic [LAG_W-1:0]   wr_ptr_q, wr_ptr_d, rd_idx_s;
  logic [63:0]        signal_q, signal_d, signal_lag_q, signal_lag_d;
  logic               strobe_q, strobe_d, underrun_q, underrun_d;
  logic [PCM_W-1:0]   conv_in_s;
  logic [63:0]        conv_out_s;

  int_to_double #(.PCM_W(PCM_W)) u_conv (
    .pcm_in  (conv_in_s),
    .dbl_out (conv_out_s)
  );

  // Sample-period counter and terminal count
  always_comb begin
    tc_s = enable_sampling && (cnt_q == CNT_LAST);
    if (!enable_sampling || tc_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Holding register, conversion sequencing and output commit
  always_comb begin
    state_d      = state_q;
    full_d       = full_q;
    hold_mic_d   = hold_mic_q;
    hold_ref_d   = hold_ref_q;
    mic_lat_d    = mic_lat_q;
    ref_lat_d    = ref_lat_q;
    mic_dbl_d    = mic_dbl_q;
    ref_dbl_d    = ref_dbl_q;
    hist_d       = hist_q;
    wr_ptr_d     = wr_ptr_q;
    signal_d     = signal_q;
    signal_lag_d = signal_lag_q;
    underrun_d   = underrun_q;
    strobe_d     = 1'b0;
    accept_s     = pcm_valid && ready_q;
    conv_in_s    = (state_q == CONV_REF) ? ref_lat_q : mic_lat_q;
    rd_idx_s     = wr_ptr_q - lag_sel;

    // ready_q is ~full_q, so an accept can never coincide with the slot being freed.
    if (accept_s) begin
      full_d     = 1'b1;
      hold_mic_d = pcm_mic;
      hold_ref_d = pcm_ref;
    end else begin
      full_d     = full_q;
    end

    case (state_q)
      IDLE: begin
        if (tc_s) begin
          state_d = CONV_MIC;
          if (full_q) begin
            mic_lat_d = hold_mic_q;
            ref_lat_d = hold_ref_q;
            full_d    = 1'b0;
          end else begin
            mic_lat_d  = '0;
            ref_lat_d  = '0;
            underrun_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CONV_MIC: begin
        mic_dbl_d = conv_out_s;
        state_d   = CONV_REF;
      end
      CONV_REF: begin
        ref_dbl_d = conv_out_s;
        state_d   = COMMIT;
      end
      COMMIT: begin
        hist_d[wr_ptr_q] = ref_dbl_q;
        signal_d         = mic_dbl_q;
        signal_lag_d     = (lag_sel == '0) ? ref_dbl_q : hist_q[rd_idx_s];
        wr_ptr_d         = wr_ptr_q + LAG_W'(1);
        strobe_d         = 1'b1;
        state_d          = STROBE;
      end
      STROBE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = ~full_d;
  end

  // State and datapath registers
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      full_q       <= 1'b0;
      ready_q      <= 1'b1;
      hold_mic_q   <= '0;
      hold_ref_q   <= '0;
      mic_lat_q    <= '0;
      ref_lat_q    <= '0;
      mic_dbl_q    <= '0;
      ref_dbl_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      signal_q     <= '0;
      signal_lag_q <= '0;
      strobe_q     <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      full_q       <= full_d;
      ready_q      <= ready_d;
      hold_mic_q   <= hold_mic_d;
      hold_ref_q   <= hold_ref_d;
      mic_lat_q    <= mic_lat_d;
      ref_lat_q    <= ref_lat_d;
      mic_dbl_q    <= mic_dbl_d;
      ref_dbl_q    <= ref_dbl_d;
      hist_q       <= hist_d;
      wr_ptr_q     <= wr_ptr_d;
      signal_q     <= signal_d;
      signal_lag_q <= signal_lag_d;
      strobe_q     <= strobe_d;
      underrun_q   <= underrun_d;
    end
  end

  assign pcm_ready              = ready_q;
  assign signal                 = signal_q;
  assign signal_lag             = signal_lag_q;
  assign sampling_cycle_counter = strobe_q;
  assign underrun               = underrun_q;
endmodule

// File: tb/tb_pcm_lag_frontend.sv
// Directed bench for pcm_lag_frontend: a reference model pushes expected strobe
// contents into a queue when a pair is driven; each strobe pops and compares.
module tb_pcm_lag_frontend;
  localparam int SP    = 620;
  localparam int PCM_W = 16;
  localparam int LAG_W = 3;

  typedef struct {
    logic [63:0] sig;
    logic [63:0] lag;
    logic        und;
  } exp_t;

  logic             clk_operation = 1'b0;
  logic             rst;
  logic             enable_sampling;
  logic [PCM_W-1:0] pcm_mic;
  logic [PCM_W-1:0] pcm_ref;
  logic             pcm_valid;
  logic             pcm_ready;
  logic [LAG_W-1:0] lag_sel;
  logic [63:0]      signal;
  logic [63:0]      signal_lag;
  logic             sampling_cycle_counter;
  logic             underrun;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  exp_t        sb[$];
  int          ref_hist[$];
  int          lag_model;
  logic        und_model;

  pcm_lag_frontend #(.SAMPLE_PERIOD(SP), .PCM_W(PCM_W), .LAG_W(LAG_W)) dut (
    .clk_operation          (clk_operation),
    .rst                    (rst),
    .enable_sampling        (enable_sampling),
    .pcm_mic                (pcm_mic),
    .pcm_ref                (pcm_ref),
    .pcm_valid              (pcm_valid),
    .pcm_ready              (pcm_ready),
    .lag_sel                (lag_sel),
    .signal                 (signal),
    .signal_lag             (signal_lag),
    .sampling_cycle_counter (sampling_cycle_counter),
    .underrun               (underrun)
  );

  always #5 clk_operation = ~clk_operation;
  always @(posedge clk_operation) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] to_dbl(input int x);
    return $realtobits($itor(x));
  endfunction

  // Reference model of one sample period; skip = no pair available at the terminal count.
  task automatic model_period(input int m, input int r, input logic skip);
    exp_t e;
    int   n;
    int   cur_m;
    int   cur_r;
    cur_m = skip ? 0 : m;
    cur_r = skip ? 0 : r;
    if (skip) und_model = 1'b1;
    n = ref_hist.size();
    e.sig = to_dbl(cur_m);
    if (lag_model == 0) e.lag = to_dbl(cur_r);
    else if (n >= lag_model) e.lag = to_dbl(ref_hist[n - lag_model]);
    else e.lag = 64'h0;
    e.und = und_model;
    ref_hist.push_back(cur_r);
    sb.push_back(e);
  endtask

  task automatic send(input int m, input int r);
    int n;
    n = 0;
    pcm_mic   = m[PCM_W-1:0];
    pcm_ref   = r[PCM_W-1:0];
    pcm_valid = 1'b1;
    while (pcm_ready !== 1'b1 && n < 2 * SP) begin
      @(posedge clk_operation); #1;
      n++;
    end
    chk("send_ready", 64'(pcm_ready), 64'd1);
    @(posedge clk_operation); #1;
    pcm_valid = 1'b0;
    model_period(m, r, 1'b0);
  endtask

  task automatic wait_strobe(input string tag, output int unsigned at_cyc);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk_operation);
    while (sampling_cycle_counter !== 1'b1 && n < 2 * SP) begin
      @(negedge clk_operation);
      n++;
    end
    at_cyc = cyc;
    chk({tag, "_seen"}, 64'(sampling_cycle_counter), 64'd1);
    chk({tag, "_pending"}, 64'(sb.size() > 0), 64'd1);
    if (sampling_cycle_counter === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_signal"}, signal, e.sig);
      chk({tag, "_signal_lag"}, signal_lag, e.lag);
      chk({tag, "_underrun"}, 64'(underrun), 64'(e.und));
    end
    @(negedge clk_operation);
    chk({tag, "_width"}, 64'(sampling_cycle_counter), 64'd0);
  endtask

  initial begin
    int unsigned cyc0, t1, t2, t3, t;
    int          n, cnt;
    rst = 1'b0; enable_sampling = 1'b1; pcm_valid = 1'b0;
    pcm_mic = '0; pcm_ref = '0; lag_sel = '0;
    lag_model = 0; und_model = 1'b0;
    repeat (3) @(posedge clk_operation); #1;
    chk("rst_signal", signal, 64'h0);
    chk("rst_signal_lag", signal_lag, 64'h0);
    chk("rst_strobe", 64'(sampling_cycle_counter), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_ready", 64'(pcm_ready), 64'd1);
    rst = 1'b1;
    cyc0 = cyc;

    // Conversion with lag 0; TC falls in cycle SP-1, strobe four cycles later.
    send(1, -32768);
    wait_strobe("conv1", t1);
    chk("first_strobe_latency", 64'(t1 - cyc0), 64'(SP + 3));
    chk("conv1_const_mic", signal, 64'h3FF0000000000000);
    chk("conv1_const_ref", signal_lag, 64'hC0E0000000000000);
    send(3, 5);
    wait_strobe("conv2", t2);
    chk("period_2", 64'(t2 - t1), 64'(SP));
    chk("conv2_const_mic", signal, 64'h4008000000000000);
    send(0, 0);
    wait_strobe("conv3", t3);
    chk("period_3", 64'(t3 - t2), 64'(SP));
    chk("conv3_const_mic", signal, 64'h0);

    // Backpressure: second pair waits until the first leaves the holding register.
    send(100, -7);
    pcm_mic = 16'hFF38; pcm_ref = 16'd9; pcm_valid = 1'b1;
    chk("bp_ready_low", 64'(pcm_ready), 64'd0);
    n = 0;
    do begin
      @(negedge clk_operation);
      n++;
    end while (pcm_ready !== 1'b1 && n < 2 * SP);
    chk("bp_ready_rise", 64'(pcm_ready), 64'd1);
    chk("bp_ready_rise_time", 64'(cyc - t3), 64'(SP - 3));
    @(posedge clk_operation); #1;
    pcm_valid = 1'b0;
    model_period(-200, 9, 1'b0);
    chk("bp_second_held", 64'(pcm_ready), 64'd0);
    wait_strobe("bp_a", t);
    wait_strobe("bp_b", t);
    chk("bp_slot_free", 64'(pcm_ready), 64'd1);

    // Mid-period reset with a pair held.
    send(55, 66);
    repeat (100) @(posedge clk_operation); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_signal", signal, 64'h0);
    chk("mid_rst_signal_lag", signal_lag, 64'h0);
    chk("mid_rst_strobe", 64'(sampling_cycle_counter), 64'd0);
    chk("mid_rst_underrun", 64'(underrun), 64'd0);
    chk("mid_rst_ready", 64'(pcm_ready), 64'd1);
    sb.delete();
    ref_hist.delete();
    und_model = 1'b0;
    lag_sel = 3'd4;
    lag_model = 4;
    @(posedge clk_operation); #1;
    rst = 1'b1;
    cyc0 = cyc;

    // Lag of four periods; warm-up slots read as zero.
    for (int i = 1; i <= 6; i++) begin
      send(10 * i, i);
      wait_strobe($sformatf("lag%0d", i), t);
      if (i == 1) chk("rst_first_strobe_latency", 64'(t - cyc0), 64'(SP + 3));
      if (i <= 4) chk($sformatf("lag%0d_warmup", i), signal_lag, 64'h0);
      if (i == 5) chk("lag5_const", signal_lag, 64'h3FF0000000000000);
      if (i == 6) chk("lag6_const", signal_lag, 64'h4000000000000000);
    end

    // Underrun: a period with no pair still strobes and the flag sticks.
    lag_sel = 3'd0;
    lag_model = 0;
    model_period(0, 0, 1'b1);
    wait_strobe("underrun", t);
    chk("underrun_const_signal", signal, 64'h0);
    chk("underrun_const_lag", signal_lag, 64'h0);
    send(7, 8);
    wait_strobe("after_underrun", t);
    chk("underrun_sticky", 64'(underrun), 64'd1);

    // Disabled sampling issues no strobes; re-enabling restarts the full period.
    enable_sampling = 1'b0;
    cnt = 0;
    for (int i = 0; i < 2 * SP + 50; i++) begin
      @(negedge clk_operation);
      if (sampling_cycle_counter === 1'b1) cnt++;
    end
    chk("disabled_no_strobe", 64'(cnt), 64'd0);
    @(posedge clk_operation); #1;
    enable_sampling = 1'b1;
    cyc0 = cyc;
    send(21, 22);
    wait_strobe("reenable", t);
    chk("reenable_latency", 64'(t - cyc0), 64'(SP + 3));

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
